// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  // Two's-complement magnitude. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? ((~x) + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

endpackage

// File: rtl/multdiv_iter_addsub.sv
// 33-bit adder/subtractor shared by the Booth, restoring-divide and
// sign fix-up paths. Subtract is done as a + ~b + 1.
module iter_addsub
  import multdiv_pkg::*;
(
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o
);

  assign sum_o = a_i + (b_i ^ {(WIDTH+1){sub_i}}) + {{WIDTH{1'b0}}, sub_i};

endmodule

// File: rtl/multdiv_iter.sv
// Iterative radix-2 multiply (Booth) / divide (restoring) unit with a
// fixed 33-cycle start-to-ready latency.
//
//   state | meaning
//   IDLE  | waiting for ctrl_MULT / ctrl_DIV
//   MUL   | one Booth add/sub + arithmetic shift per cycle, 32 cycles
//   DIV   | one trial subtract + shift per cycle on magnitudes, 32 cycles
//   FIX   | sign / exception fix-up, register result, pulse ready
//
// Register sharing: acc_q is the Booth accumulator or the division
// remainder; mq_q is the multiplier or the dividend/quotient; m_q is the
// multiplicand or the divisor magnitude.
module multdiv_iter
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             q1_q, q1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH:0]   as_a, as_b, as_sum;
  logic             as_sub;
  logic [WIDTH:0]   acc_pre;
  logic [WIDTH:0]   prod_hi;
  logic             start;

  assign start = ctrl_MULT | ctrl_DIV;

  iter_addsub u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .sum_o (as_sum)
  );

  // Steer the single adder: Booth step, trial subtract, or quotient negate.
  always_comb begin
    as_a   = '0;
    as_b   = '0;
    as_sub = 1'b0;
    case (state_q)
      MUL: begin
        as_a   = acc_q;
        as_b   = {m_q[WIDTH-1], m_q};
        as_sub = mq_q[0] & ~q1_q;
      end
      DIV: begin
        as_a   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        as_b   = {1'b0, m_q};
        as_sub = 1'b1;
      end
      FIX: begin
        as_a   = '0;
        as_b   = {1'b0, mq_q};
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state, iteration datapath, fix-up and start/abort latching.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    q1_d     = q1_q;
    m_d      = m_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    acc_pre  = acc_q;
    prod_hi  = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};

    case (state_q)
      MUL: begin
        acc_pre = (mq_q[0] ^ q1_q) ? as_sum : acc_q;
        acc_d   = {acc_pre[WIDTH], acc_pre[WIDTH:1]};
        mq_d    = {acc_pre[0], mq_q[WIDTH-1:1]};
        q1_d    = mq_q[0];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      end
      DIV: begin
        // Remainder stays below the divisor (<= 2^31), so the shifted
        // partial remainder never exceeds 33 bits and bit 32 is the sign.
        if (!as_sum[WIDTH]) begin
          acc_d = {1'b0, as_sum[WIDTH-1:0]};
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {1'b0, acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
        if (op_div_q) begin
          if (dz_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = neg_q ? as_sum[WIDTH-1:0] : mq_q;
            exc_d    = ovf_q;
          end
        end else begin
          result_d = mq_q;
          exc_d    = ~((&prod_hi) | ~(|prod_hi));
        end
      end
      default: ;
    endcase

    // A start in any state (re)launches; FIX outputs above still commit.
    if (start) begin
      cnt_d    = '0;
      acc_d    = '0;
      q1_d     = 1'b0;
      op_div_d = ~ctrl_MULT;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz_d     = (data_operandB == '0);
      ovf_d    = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                 (data_operandB == '1);
      if (ctrl_MULT) begin
        state_d = MUL;
        mq_d    = data_operandB;
        m_d     = data_operandA;
      end else begin
        state_d = DIV;
        mq_d    = abs_val(data_operandA);
        m_d     = abs_val(data_operandB);
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Self-checking bench for multdiv_iter: vector table plus scoreboard,
// with hand-written abort / reset / back-to-back sequences.
module tb_multdiv_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        c_mult = 1'b0;
  logic        c_div = 1'b0;
  logic [31:0] res;
  logic        exc;
  logic        rdy;

  multdiv_iter dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (c_mult),
    .ctrl_DIV       (c_div),
    .data_result    (res),
    .data_exception (exc),
    .data_resultRDY (rdy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          start_cyc;
  } exp_t;

  typedef struct {
    string       name;
    bit          is_div;
    bit          both;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference using native 64-bit multiply and int divide.
  function automatic exp_t model(input bit is_div, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx;
    longint      sy;
    logic [63:0] pv;
    logic [32:0] hi;
    int          q;
    e.start_cyc = 0;
    if (!is_div) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      pv = sx * sy;
      hi = pv[63:31];
      e.res = pv[31:0];
      e.exc = !(hi == '0 || hi == '1);
    end else if (y == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      q = $signed(x) / $signed(y);
      e.res = q;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  task automatic start_op(input bit is_div, input bit both, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eres, input bit eexc,
                          input bit abort);
    exp_t e;
    @(negedge clock);
    op_a   = x;
    op_b   = y;
    c_mult = !is_div || both;
    c_div  = is_div || both;
    e.res = eres;
    e.exc = eexc;
    e.start_cyc = cyc + 1;
    if (abort) sb.delete();
    sb.push_back(e);
    @(negedge clock);
    c_mult = 1'b0;
    c_div  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest pending op.
  initial begin
    logic prev_rdy;
    exp_t e;
    prev_rdy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (rdy) begin
        chk("rdy_expected", sb.size() != 0, 1);
        chk("rdy_single", prev_rdy, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result", res, e.res);
          chk("exception", exc, e.exc);
          chk("latency", cyc - e.start_cyc, 33);
          last_res = e.res;
        end
      end
      prev_rdy = rdy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    exp_t        e;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] held;

    vecs.push_back('{"mul_7x-3",      0, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0});
    vecs.push_back('{"mul_ovf_2^32",  0, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1});
    vecs.push_back('{"mul_min_x1",    0, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0});
    vecs.push_back('{"mul_-1x-1",     0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         0});
    vecs.push_back('{"mul_max_x2",    0, 0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1});
    vecs.push_back('{"div_-7/2",      1, 0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0});
    vecs.push_back('{"div_7/-2",      1, 0, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0});
    vecs.push_back('{"div_100/0",     1, 0, 32'd100,        32'd0,         32'd0,         1});
    vecs.push_back('{"div_min/-1",    1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{"div_-100/-7",   1, 0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        0});
    vecs.push_back('{"div_0/5",       1, 0, 32'd0,          32'd5,         32'd0,         0});
    vecs.push_back('{"both_6_2",      0, 1, 32'd6,          32'd2,         32'd12,        0});

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_result", res, 0);
    chk("rst_exc", exc, 0);
    chk("rst_rdy", rdy, 0);

    foreach (vecs[i]) begin
      start_op(vecs[i].is_div, vecs[i].both, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].exc, 1'b0);
      wait_done(vecs[i].name);
    end

    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 2 == 1) y = y >> $urandom_range(0, 31);
      e = model(i % 2 == 1, x, y);
      start_op(i % 2 == 1, 1'b0, x, y, e.res, e.exc, 1'b0);
      wait_done("random");
    end

    // Outputs hold the previous result while a new operation runs.
    held = last_res;
    start_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    chk("hold_result", res, held);
    wait_done("hold_op");

    // Abort: DIV pulse at cycle 10 of a MULT; only the DIV completes.
    start_op(1'b0, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0, 1'b0);
    repeat (8) @(negedge clock);
    start_op(1'b1, 1'b0, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1);
    wait_done("abort_div");

    // Start on the FIX edge: both operations report.
    start_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
    repeat (31) @(negedge clock);
    start_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
    wait_done("fix_edge_start");

    // Reset at cycle 15 of a MULT: outputs cleared, no ready.
    start_op(1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060, 1'b0, 1'b0);
    repeat (13) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_result", res, 0);
    chk("midrst_exc", exc, 0);
    chk("midrst_rdy", rdy, 0);
    repeat (40) @(negedge clock);

    // Reset and start on the same edge: reset wins, no operation starts.
    start_op(1'b0, 1'b0, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
    wait_done("pre_rst_start");
    chk("pre_rst_start_result", res, 42);
    @(negedge clock);
    reset  = 1'b1;
    c_mult = 1'b1;
    op_a   = 32'd3;
    op_b   = 32'd3;
    @(negedge clock);
    reset  = 1'b0;
    c_mult = 1'b0;
    chk("rst_start_result", res, 0);
    repeat (40) @(negedge clock);
    chk("rst_start_idle_result", res, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
